mental_sum_game_n: RTL

Parametrised mental-arithmetic game engine for the CPLD board, and the generalised successor of the fixed 3-term, 2-level game.
- Shows NUM_TERMS pseudo-random numbers per round, one at a time, then waits for the player's answer and compares it to their exact sum.
- Each round is one level, up to NUM_LEVELS levels; per-number dwell time shrinks as the level rises.
- Sits between the 1 Hz tick generator, the switch bank, and the BCD/7-seg and LED drivers.

---
 rtl/mental_sum_game_n.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mental_sum_game_n.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mental_sum_game_n                                                |
// | Purpose  : mental-arithmetic game; shows NUM_TERMS LFSR numbers per level,  |
// |            then checks the player's answer against their sum.               |
// | Options  : MENTAL_SUM_ANS_TIMEOUT_EN enables the ANS_TICKS answer timeout.  |
// | Revision : 1.0 - initial parametrised release                               |
// +-----------------------------------------------------------------------------+
module mental_sum_game_n #(
  parameter int                LFSR_W      = 5,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 5'b10101,
  parameter logic [LFSR_W-1:0] LFSR_TAPS   = 5'b10100,
  parameter int                ANS_W       = 8,
  parameter int                NUM_TERMS   = 3,
  parameter int                NUM_LEVELS  = 4,
  parameter int                BASE_DWELL  = 5,
  parameter int                DWELL_STEP  = 1,
  parameter int                MIN_DWELL   = 1,
  parameter int                COUNTDOWN   = 3,
  parameter int                RESULT_HOLD = 2,
  parameter int                PASS_CODE   = 11,
  parameter int                ANS_TICKS   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic [ANS_W-1:0]  answer,
  input  logic              submit,
  output logic [ANS_W-1:0]  disp_value,
  output logic [LFSR_W-1:0] led,
  output logic [2:0]        level,
  output logic              pass,
  output logic              fail,
  output logic              busy,
  output logic              win
);

`ifdef MENTAL_SUM_ANS_TIMEOUT_EN
  localparam bit c_timeout_en = 1'b1;
`else
  localparam bit c_timeout_en = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW     = 3'd1,
    S_WAIT_ANS = 3'd2,
    S_RESULT   = 3'd3,
    S_CNTDN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            r_state, w_state_n;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_n;
  logic [ANS_W-1:0]  r_sum, w_sum_n;
  logic [3:0]        r_term, w_term_n;
  logic [15:0]       r_cnt, w_cnt_n;
  logic              r_passed, w_passed_n;
  logic [ANS_W-1:0]  w_disp_n;
  logic [LFSR_W-1:0] w_led_n;
  logic [2:0]        w_level_n;
  logic              w_pass_n, w_fail_n, w_win_n, w_busy_n;
  logic              w_load, w_clear_sum, w_fb;
  int                w_dwell;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  // Done in int so a large (level-1)*DWELL_STEP cannot wrap below the floor.
  always_comb begin
    w_dwell = BASE_DWELL - (int'(level) - 1) * DWELL_STEP;
    if (w_dwell < MIN_DWELL) w_dwell = MIN_DWELL;
  end

  always_comb begin
    w_state_n   = r_state;
    w_lfsr_n    = r_lfsr;
    w_sum_n     = r_sum;
    w_term_n    = r_term;
    w_cnt_n     = r_cnt;
    w_passed_n  = r_passed;
    w_disp_n    = disp_value;
    w_led_n     = led;
    w_level_n   = level;
    w_pass_n    = pass;
    w_fail_n    = fail;
    w_win_n     = win;
    w_load      = 1'b0;
    w_clear_sum = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_n   = S_SHOW;
          w_level_n   = 3'd1;
          w_win_n     = 1'b0;
          w_term_n    = 4'd0;
          w_load      = 1'b1;
          w_clear_sum = 1'b1;
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (int'(r_cnt) + 1 >= w_dwell) begin
            if (int'(r_term) >= NUM_TERMS - 1) begin
              w_state_n = S_WAIT_ANS;
              w_disp_n  = '0;
              w_led_n   = '0;
              w_cnt_n   = '0;
            end else begin
              w_term_n = r_term + 4'd1;
              w_load   = 1'b1;
            end
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
      end
      S_WAIT_ANS: begin
        if (submit) begin
          w_state_n = S_RESULT;
          w_cnt_n   = '0;
          if (answer == r_sum) begin
            w_pass_n   = 1'b1;
            w_passed_n = 1'b1;
            w_disp_n   = ANS_W'(PASS_CODE);
          end else begin
            w_fail_n   = 1'b1;
            w_passed_n = 1'b0;
            w_disp_n   = '0;
          end
        end else if (c_timeout_en && tick) begin
          if (int'(r_cnt) + 1 >= ANS_TICKS) begin
            w_state_n  = S_RESULT;
            w_cnt_n    = '0;
            w_fail_n   = 1'b1;
            w_passed_n = 1'b0;
            w_disp_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
      end
      S_RESULT: begin
        if (tick) begin
          if (int'(r_cnt) + 1 >= RESULT_HOLD) begin
            w_pass_n = 1'b0;
            w_fail_n = 1'b0;
            if (r_passed && int'(level) < NUM_LEVELS) begin
              w_state_n = S_CNTDN;
              w_cnt_n   = 16'(COUNTDOWN);
              w_disp_n  = ANS_W'(COUNTDOWN);
            end else begin
              w_state_n = S_DONE;
              w_win_n   = r_passed;
              w_disp_n  = '0;
            end
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
      end
      S_CNTDN: begin
        // r_cnt mirrors the countdown value currently on the display.
        if (tick) begin
          if (r_cnt <= 16'd1) begin
            w_state_n   = S_SHOW;
            w_level_n   = level + 3'd1;
            w_term_n    = 4'd0;
            w_load      = 1'b1;
            w_clear_sum = 1'b1;
          end else begin
            w_cnt_n  = r_cnt - 16'd1;
            w_disp_n = ANS_W'(r_cnt - 16'd1);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_load) begin
      w_disp_n = ANS_W'(r_lfsr);
      w_led_n  = r_lfsr;
      w_sum_n  = (w_clear_sum ? '0 : r_sum) + ANS_W'(r_lfsr);
      w_lfsr_n = {r_lfsr[LFSR_W-2:0], w_fb};
      w_cnt_n  = '0;
    end

    w_busy_n = (w_state_n != S_IDLE) && (w_state_n != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_sum      <= '0;
      r_term     <= '0;
      r_cnt      <= '0;
      r_passed   <= 1'b0;
      disp_value <= '0;
      led        <= '0;
      level      <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      busy       <= 1'b0;
      win        <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_lfsr     <= w_lfsr_n;
      r_sum      <= w_sum_n;
      r_term     <= w_term_n;
      r_cnt      <= w_cnt_n;
      r_passed   <= w_passed_n;
      disp_value <= w_disp_n;
      led        <= w_led_n;
      level      <= w_level_n;
      pass       <= w_pass_n;
      fail       <= w_fail_n;
      busy       <= w_busy_n;
      win        <= w_win_n;
    end
  end

endmodule
`default_nettype wire
